// File: rtl/demux_dispatch_if.sv
// demux_dispatch_if: handshake and data bundle around the dispatcher.
//   Input stream : in_data, in_dest, in_valid -> in_ready
//   Controls     : mode (0 tag, 1 round-robin), flush
//   Output side  : data_out/sel to the demux, out_valid0/1 <- out_ready0/1
//   Status       : count0/count1 per-destination delivery counters
// Modport slave is the dispatcher's view, master the surrounding logic's view.
interface demux_dispatch_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_dest;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic             flush;
    logic [WIDTH-1:0] data_out;
    logic             sel;
    logic             out_valid0;
    logic             out_ready0;
    logic             out_valid1;
    logic             out_ready1;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;

    modport slave (
        input  in_data, in_dest, in_valid, mode, flush, out_ready0, out_ready1,
        output in_ready, data_out, sel, out_valid0, out_valid1, count0, count1
    );

    modport master (
        output in_data, in_dest, in_valid, mode, flush, out_ready0, out_ready1,
        input  in_ready, data_out, sel, out_valid0, out_valid1, count0, count1
    );
endinterface

// File: rtl/demux_dispatch.sv
// demux_dispatch: single-entry buffered dispatcher feeding a 1-to-2 demux.
// Holds one word plus its destination; destination comes from the word's tag
// (mode=0) or a round-robin pointer (mode=1). Deliveries are counted per
// destination with wrapping counters.
// Ports: clk, rst (async, active high), bus (demux_dispatch_if.slave).

// Per-destination delivery counter; wraps silently.
module demux_dispatch_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
endmodule

module demux_dispatch #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    demux_dispatch_if.slave   bus
);
    localparam int NUM_DEST = 2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                             state;
    logic [WIDTH-1:0]                   data_q;
    logic                               sel_q;
    logic                               rr;
    logic [NUM_DEST-1:0]                vld;
    logic [NUM_DEST-1:0]                rdy;
    logic [NUM_DEST-1:0]                dlv;
    logic [NUM_DEST-1:0][CNT_W-1:0]     cnt;
    logic                               delivery;
    logic                               accept;

    assign rdy = {bus.out_ready1, bus.out_ready0};

    // Valid only toward the held destination; the other ready is ignored
    // because its valid is forced low. Flush suppresses delivery.
    for (genvar k = 0; k < NUM_DEST; k++) begin : g_dest
        assign vld[k] = (state == FULL) && (sel_q == 1'(k));
        assign dlv[k] = vld[k] && rdy[k] && !bus.flush;

        demux_dispatch_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (dlv[k]),
            .cnt (cnt[k])
        );
    end

    assign delivery = |dlv;
    // Pass-through: a delivering slot can be refilled in the same cycle.
    // in_valid never feeds the output valids.
    assign bus.in_ready = !bus.flush && ((state == EMPTY) || delivery);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            data_q <= '0;
            sel_q  <= 1'b0;
            rr     <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= FULL;
                        data_q <= bus.in_data;
                        sel_q  <= bus.mode ? rr : bus.in_dest;
                        if (bus.mode)
                            rr <= ~rr;
                    end
                end
                FULL: begin
                    if (accept) begin
                        data_q <= bus.in_data;
                        sel_q  <= bus.mode ? rr : bus.in_dest;
                        if (bus.mode)
                            rr <= ~rr;
                    end else if (bus.flush || delivery) begin
                        // data_q/sel_q keep their last values when emptied
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.sel        = sel_q;
    assign bus.out_valid0 = vld[0];
    assign bus.out_valid1 = vld[1];
    assign bus.count0     = cnt[0];
    assign bus.count1     = cnt[1];
endmodule
